// File: rtl/silencer_pkg.sv
// silencer_pkg: shared types and default sizes for the duty slew limiter
package silencer_pkg;
  localparam int WIDTH_DEF = 13;
  localparam int DEPTH_DEF = 249;
  localparam int IDX_W = $clog2(DEPTH_DEF);
  typedef logic [WIDTH_DEF-1:0] duty_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} silencer_state_t;
endpackage

// File: rtl/duty_step.sv
// duty_step: one-channel slew step, moves cur toward tgt by at most step
// ports: cur (present duty), tgt (target duty), step (max change, 0 = jump), nxt (next duty)
module duty_step
  import silencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] nxt
);
  logic signed [WIDTH:0] d;
  logic [WIDTH:0] mag;
  // a step is only taken when |d| > step, so cur +/- step stays strictly
  // between cur and tgt and can neither overshoot nor wrap
  always_comb begin
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag = d[WIDTH] ? $unsigned(-d) : $unsigned(d);
    nxt = (step == '0 || mag <= {1'b0, step}) ? tgt : d[WIDTH] ? cur - step : cur + step;
  end
endmodule

// File: rtl/duty_silencer.sv
// duty_silencer: serial per-channel duty slew limiter downstream of modulation
// ports: CLK/RST_N (async active-low), STEP (max change per tick), SILENT_CYCLE (clocks per tick, 0 = frozen),
//        DUTY_M/DUTY_M_VALID (target array and latch strobe), DUTY_S (slewed duties), OUT_VALID (sweep done pulse)
module duty_silencer
  import silencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [WIDTH-1:0]            STEP,
  input  logic [15:0]                 SILENT_CYCLE,
  input  logic [DEPTH-1:0][WIDTH-1:0] DUTY_M,
  input  logic                        DUTY_M_VALID,
  output logic [DEPTH-1:0][WIDTH-1:0] DUTY_S,
  output logic                        OUT_VALID
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  silencer_state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [15:0] cnt, sc_q;
  logic tick;
  logic [DEPTH-1:0][WIDTH-1:0] target;
  logic [WIDTH-1:0] nxt;
  assign tick = SILENT_CYCLE != 16'd0 && cnt == SILENT_CYCLE - 16'd1;
  // a changed period restarts the count so the new tick spacing applies cleanly
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      cnt <= '0;
      sc_q <= '0;
    end else begin
      sc_q <= SILENT_CYCLE;
      cnt <= (SILENT_CYCLE != sc_q || SILENT_CYCLE == 16'd0 || tick) ? '0 : cnt + 16'd1;
    end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  // ticks arriving outside IDLE are dropped
  always_comb
    state_nx = state == IDLE ? (tick ? SWEEP : IDLE) :
               state == SWEEP ? (idx == LAST ? DONE : SWEEP) : IDLE;
  always_comb OUT_VALID = state == DONE;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) idx <= '0;
    else idx <= (state == SWEEP && idx != LAST) ? idx + 1'b1 : '0;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) target <= '0;
    else if (DUTY_M_VALID) target <= DUTY_M;
  duty_step #(.WIDTH(WIDTH)) u_step (
    .cur (DUTY_S[idx]),
    .tgt (target[idx]),
    .step(STEP),
    .nxt (nxt)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) DUTY_S <= '0;
    else if (state == SWEEP) DUTY_S[idx] <= nxt;
endmodule

// File: tb/tb_duty_silencer.sv
// tb_duty_silencer: directed self-checking bench for duty_silencer
module tb_duty_silencer;
  localparam int W = 13;
  localparam int D = 249;
  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] step;
  logic [15:0] sc;
  logic [D-1:0][W-1:0] duty_m, duty_s;
  logic duty_m_valid, out_valid;
  logic [W-1:0] exp_v [D];
  int vectors = 0;
  int miss = 0;

  always #5 clk = ~clk;

  duty_silencer #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(clk), .RST_N(rst_n), .STEP(step), .SILENT_CYCLE(sc),
    .DUTY_M(duty_m), .DUTY_M_VALID(duty_m_valid), .DUTY_S(duty_s), .OUT_VALID(out_valid)
  );

  function automatic int mism(output int first);
    int b = 0;
    first = -1;
    for (int k = 0; k < D; k++)
      if (duty_s[k] !== exp_v[k]) begin
        if (b == 0) first = k;
        b++;
      end
    return b;
  endfunction

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; step = 13'd100; sc = 16'd300; duty_m = '0; duty_m_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (duty_s !== '0) begin miss++; $display("FAIL reset_duty: got %h want 0", duty_s[0]); end
    vectors++;
    if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    rst_n = 1'b1;
  endtask

  task automatic test_slew;
    int n, f, b;
    for (int k = 0; k < D; k++) duty_m[k] = 13'd1000;
    duty_m_valid = 1'b1;
    @(negedge clk);
    duty_m_valid = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      wait_valid(700, n);
      vectors++;
      if (n == 0) begin miss++; $display("FAIL slew_timeout tick %0d: no OUT_VALID within 700 cycles", t); end
      for (int k = 0; k < D; k++) exp_v[k] = (t * 100 > 1000) ? 13'd1000 : W'(t * 100);
      b = mism(f);
      vectors++;
      if (b != 0) begin miss++; $display("FAIL slew tick %0d: %0d channels wrong, ch%0d got %0d want %0d", t, b, f, duty_s[f], exp_v[f]); end
    end
  endtask

  task automatic test_downward;
    int n, f, b;
    for (int k = 0; k < D; k++) begin duty_m[k] = 13'd950; exp_v[k] = 13'd950; end
    duty_m_valid = 1'b1;
    @(negedge clk);
    duty_m_valid = 1'b0;
    wait_valid(700, n);
    vectors++;
    if (n == 0) begin miss++; $display("FAIL down_timeout: no OUT_VALID within 700 cycles"); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL downward: %0d channels wrong, ch%0d got %0d want 950", b, f, duty_s[f]); end
  endtask

  // a new SILENT_CYCLE restarts the count, so the tick lands at a known cycle
  task automatic test_bypass;
    int pulses = 0, first = 0, f, b;
    step = '0; sc = 16'd400;
    for (int k = 0; k < D; k++) begin duty_m[k] = W'(k * 30); exp_v[k] = W'(k * 30); end
    duty_m_valid = 1'b1;
    for (int n = 1; n <= 700; n++) begin
      @(negedge clk);
      if (n == 1) duty_m_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    vectors++;
    if (pulses != 1) begin miss++; $display("FAIL bypass_pulses: got %0d want 1", pulses); end
    vectors++;
    if (first != 400 + D + 1) begin miss++; $display("FAIL bypass_latency: got %0d want %0d", first, 400 + D + 1); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL bypass: %0d channels wrong, ch%0d got %0d want %0d", b, f, duty_s[f], exp_v[f]); end
  endtask

  task automatic test_boundaries;
    int n, f, b;
    step = 13'd8191;
    for (int k = 0; k < D; k++) begin duty_m[k] = 13'd8191; exp_v[k] = 13'd8191; end
    duty_m_valid = 1'b1;
    @(negedge clk);
    duty_m_valid = 1'b0;
    wait_valid(1000, n);
    vectors++;
    if (n == 0) begin miss++; $display("FAIL max_timeout: no OUT_VALID within 1000 cycles"); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL max_step: %0d channels wrong, ch%0d got %0d want 8191", b, f, duty_s[f]); end
    step = 13'd1;
    for (int k = 0; k < D; k++) begin duty_m[k] = '0; exp_v[k] = 13'd8190; end
    duty_m_valid = 1'b1;
    @(negedge clk);
    duty_m_valid = 1'b0;
    wait_valid(1000, n);
    vectors++;
    if (n == 0) begin miss++; $display("FAIL min_timeout: no OUT_VALID within 1000 cycles"); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL no_wrap: %0d channels wrong, ch%0d got %0d want 8190", b, f, duty_s[f]); end
  endtask

  // tick at n=300, channel i is swept in cycle n=301+i; the strobe sampled
  // at the end of n=400 (channel 99) is seen from channel 100 onward
  task automatic test_mid_latch;
    int pulses = 0, first = 0, f, b;
    step = '0; sc = 16'd300;
    for (int k = 0; k < D; k++) begin duty_m[k] = 13'd200; exp_v[k] = k < 100 ? 13'd200 : 13'd500; end
    duty_m_valid = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (n == 1) duty_m_valid = 1'b0;
      if (n == 400) begin
        for (int k = 0; k < D; k++) duty_m[k] = 13'd500;
        duty_m_valid = 1'b1;
      end
      if (n == 401) duty_m_valid = 1'b0;
      if (out_valid) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    vectors++;
    if (pulses != 1 || first != 300 + D + 1) begin miss++; $display("FAIL mid_pulse: got %0d pulses at %0d want 1 at %0d", pulses, first, 300 + D + 1); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL mid_latch: %0d channels wrong, ch%0d got %0d want %0d", b, f, duty_s[f], exp_v[f]); end
  endtask

  task automatic test_reset_mid;
    int n, f, b, pulses = 0;
    wait_valid(700, n);
    vectors++;
    if (n == 0) begin miss++; $display("FAIL resync_timeout: no OUT_VALID within 700 cycles"); end
    sc = 16'd350;
    for (int k = 0; k < D; k++) duty_m[k] = 13'd777;
    duty_m_valid = 1'b1;
    for (int i = 1; i <= 401; i++) begin
      @(negedge clk);
      if (i == 1) duty_m_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (duty_s !== '0) begin miss++; $display("FAIL reset_mid_duty: ch0 got %0d ch10 got %0d want 0", duty_s[0], duty_s[10]); end
    vectors++;
    if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_mid_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miss++; $display("FAIL reset_hold: got %0d pulses want 0", pulses); end
    rst_n = 1'b1;
    for (int k = 0; k < D; k++) begin duty_m[k] = 13'd321; exp_v[k] = 13'd321; end
    duty_m_valid = 1'b1;
    @(negedge clk);
    duty_m_valid = 1'b0;
    wait_valid(800, n);
    vectors++;
    if (n == 0) begin miss++; $display("FAIL restart_timeout: no OUT_VALID within 800 cycles"); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL restart: %0d channels wrong, ch%0d got %0d want 321", b, f, duty_s[f]); end
  endtask

  task automatic test_silent_zero;
    int pulses = 0, f, b;
    sc = '0;
    for (int k = 0; k < D; k++) duty_m[k] = 13'd4000;
    duty_m_valid = 1'b1;
    for (int n = 1; n <= 10000; n++) begin
      @(negedge clk);
      if (n == 1) duty_m_valid = 1'b0;
      if (out_valid) pulses++;
    end
    vectors++;
    if (pulses != 0) begin miss++; $display("FAIL silent_zero: got %0d pulses want 0", pulses); end
    b = mism(f);
    vectors++;
    if (b != 0) begin miss++; $display("FAIL frozen: %0d channels wrong, ch%0d got %0d want 321", b, f, duty_s[f]); end
  endtask

  initial begin
    test_reset();
    test_slew();
    test_downward();
    test_bypass();
    test_boundaries();
    test_mid_latch();
    test_reset_mid();
    test_silent_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
